// File: rtl/lottery_draw_tx.sv
// lottery_draw_tx: draws a five-digit BCD number from a free-running LFSR,
// shows it on five seven-segment displays and sends it digit by digit over
// the num/insert/finish entry interface.
module lottery_draw_tx #(
    parameter logic [15:0] SEED = 16'h0001,
    parameter int          GAP  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        draw,
    output logic [3:0]  num,
    output logic        insert,
    output logic        finish,
    output logic        busy,
    output logic        done,
    output logic [19:0] drawn,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX0
);

    // An all-zero LFSR would lock up, so a zero seed is swapped for a known one.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [3:0]  GAP_LAST = 4'(GAP - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CAPTURE = 3'd1;
    localparam logic [2:0] S_SEND    = 3'd2;
    localparam logic [2:0] S_GAP     = 3'd3;
    localparam logic [2:0] S_FINISH  = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [15:0]     lfsr;
    logic [2:0]      state;
    logic [2:0]      k;          // digit index for capture and send
    logic [3:0]      gcnt;       // remaining gap cycles minus one
    logic [3:0]      fold;
    logic [2:0]      slot;       // packed-array slot of digit k (digit0 in slot 4)
    logic [2:0]      slot_nxt;   // slot of digit k+1
    logic [4:0][3:0] dig_r;
    logic [4:0][6:0] hex_r;

    // Active-low {g,f,e,d,c,b,a} pattern for one BCD digit.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // Free-running Fibonacci LFSR; it never pauses, so draw timing adds entropy.
    always_ff @(posedge clk) begin
        if (reset) lfsr <= SEED_EFF;
        else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    // Fold the low nibble into 0..9 and locate the digit slots for index k.
    always_comb begin
        fold     = (lfsr[3:0] > 4'd9) ? (lfsr[3:0] - 4'd10) : lfsr[3:0];
        slot     = 3'd4 - k;
        slot_nxt = 3'd3 - k;
    end

    // Draw/transmit sequencer; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            k      <= '0;
            gcnt   <= '0;
            num    <= '0;
            insert <= 1'b0;
            finish <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            dig_r  <= '0;
            hex_r  <= {5{7'b1111111}};
        end else begin
            insert <= 1'b0;
            finish <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (draw) begin
                        state <= S_CAPTURE;
                        k     <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                S_CAPTURE: begin
                    dig_r[slot] <= fold;
                    hex_r[slot] <= seg7(fold);
                    if (k == 3'd4) begin
                        state  <= S_SEND;
                        k      <= '0;
                        insert <= 1'b1;
                        num    <= dig_r[4];
                    end else begin
                        k <= k + 3'd1;
                    end
                end
                S_SEND: begin
                    state <= S_GAP;
                    gcnt  <= GAP_LAST;
                end
                S_GAP: begin
                    if (gcnt != 4'd0) begin
                        gcnt <= gcnt - 4'd1;
                    end else if (k == 3'd4) begin
                        state  <= S_FINISH;
                        finish <= 1'b1;
                    end else begin
                        state  <= S_SEND;
                        k      <= k + 3'd1;
                        insert <= 1'b1;
                        num    <= dig_r[slot_nxt];
                    end
                end
                S_FINISH: begin
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign drawn = dig_r;
    assign HEX4  = hex_r[4];
    assign HEX3  = hex_r[3];
    assign HEX2  = hex_r[2];
    assign HEX1  = hex_r[1];
    assign HEX0  = hex_r[0];

endmodule

// File: tb/tb_lottery_draw_tx.sv
// Bench for lottery_draw_tx: a cycle-number model of the main instance checked
// every cycle, plus hand-computed literals for seeds 1, 6 and 0.
module tb_lottery_draw_tx;

    localparam int P   = 3;           // 1 + GAP
    localparam int FIN = 6 + 5 * P;   // finish cycle

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic draw = 1'b0, draw6 = 1'b0, draw0 = 1'b0;

    logic [3:0]  num, num6, num0;
    logic        insert, finish, busy, done;
    logic        insert6, finish6, busy6, done6;
    logic        insert0, finish0, busy0, done0;
    logic [19:0] drawn, drawn6, drawn0;
    logic [6:0]  h4, h3, h2, h1, h0;
    logic [6:0]  g4, g3, g2, g1, g0;
    logic [6:0]  z4, z3, z2, z1, z0;

    lottery_draw_tx #(.SEED(16'h0001), .GAP(2)) dut (
        .clk(clk), .reset(reset), .draw(draw), .num(num), .insert(insert),
        .finish(finish), .busy(busy), .done(done), .drawn(drawn),
        .HEX4(h4), .HEX3(h3), .HEX2(h2), .HEX1(h1), .HEX0(h0));

    lottery_draw_tx #(.SEED(16'h0006), .GAP(2)) dut6 (
        .clk(clk), .reset(reset), .draw(draw6), .num(num6), .insert(insert6),
        .finish(finish6), .busy(busy6), .done(done6), .drawn(drawn6),
        .HEX4(g4), .HEX3(g3), .HEX2(g2), .HEX1(g1), .HEX0(g0));

    lottery_draw_tx #(.SEED(16'h0000), .GAP(2)) dut0 (
        .clk(clk), .reset(reset), .draw(draw0), .num(num0), .insert(insert0),
        .finish(finish0), .busy(busy0), .done(done0), .drawn(drawn0),
        .HEX4(z4), .HEX3(z3), .HEX2(z2), .HEX1(z1), .HEX0(z0));

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int n_ins = 0, n_fin = 0, d0_cnt = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [3:0] fold(input logic [3:0] n);
        return (n > 4'd9) ? n - 4'd10 : n;
    endfunction

    // Model: m_n is the cycle number within the current draw (0 = not drawing).
    int         m_n = 0;
    logic       m_done = 1'b0;
    logic [3:0] m_num = '0;
    logic [3:0] m_dig [5];
    logic [4:0] m_hv = '0;
    logic [15:0] m_l = '0;

    function automatic bit exp_ins(input int n);
        return n >= 6 && n <= 6 + 4 * P && (n - 6) % P == 0;
    endfunction

    initial begin
        for (int i = 0; i < 5; i++) m_dig[i] = '0;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_l = 16'h0001; m_n = 0; m_done = 1'b0; m_num = '0; m_hv = '0;
                for (int i = 0; i < 5; i++) m_dig[i] = '0;
            end else begin
                if (m_n >= 1 && m_n <= 5) begin
                    m_dig[m_n - 1] = fold(m_l[3:0]);
                    m_hv[m_n - 1]  = 1'b1;
                end
                if (m_n == 0) begin
                    if (draw) begin m_n = 1; m_done = 1'b0; end
                end else if (m_n == FIN) begin
                    m_n = 0; m_done = 1'b1;
                end else begin
                    m_n++;
                end
                if (exp_ins(m_n)) m_num = m_dig[(m_n - 6) / P];
                m_l = lfsr_next(m_l);
            end
        end
    end

    // Every-cycle comparison of the main instance against the model.
    initial begin
        logic [34:0] ehex;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                ehex = '0;
                for (int i = 0; i < 5; i++)
                    ehex[34 - 7 * i -: 7] = m_hv[i] ? SEG[m_dig[i]] : 7'h7F;
                check("strobes", {insert, finish, busy, done},
                      {exp_ins(m_n), m_n == FIN, m_n >= 1, m_done});
                check("num", num, m_num);
                check("drawn", drawn, {m_dig[0], m_dig[1], m_dig[2], m_dig[3], m_dig[4]});
                check("hex", {h4, h3, h2, h1, h0}, ehex);
                check("ins_fin_excl", insert & finish, 1'b0);
                if (insert) n_ins++;
                if (finish) n_fin++;
                if (done0) begin
                    d0_cnt++;
                    check("dut0_digits_le9",
                          {drawn0[19:16] <= 4'd9, drawn0[15:12] <= 4'd9, drawn0[11:8] <= 4'd9,
                           drawn0[7:4] <= 4'd9, drawn0[3:0] <= 4'd9}, 5'b11111);
                end
            end
        end
    end

    task automatic goto(input int c);
        while (cyc < c) begin @(negedge clk); cyc++; end
    endtask

    // Reset for one cycle, then request a draw sampled at the next edge (E0).
    task automatic reset_and_draw(input bit hold);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; draw = 1'b1; cyc = 0;
        goto(1);
        if (!hold) draw = 1'b0;
    endtask

    initial begin
        int bi, bf, b0;
        @(negedge clk); @(negedge clk);
        chk_en = 1'b1;
        check("rst_out", {num, insert, finish, busy, done, drawn}, '0);
        check("rst_hex", {h4, h3, h2, h1, h0}, {5{7'b1111111}});

        // Basic draw on all three seeds, with an ignored request in cycle 10.
        reset = 1'b0; draw = 1'b1; draw6 = 1'b1; draw0 = 1'b1; cyc = 0;
        bi = n_ins; bf = n_fin;
        goto(1); draw = 1'b0; draw6 = 1'b0; draw0 = 1'b0;
        goto(2);  check("c2_digit0", drawn[19:16], 4'd2);
                  check("c2_hex4", h4, 7'b0100100);
        goto(6);  check("c6_insert_num", {insert, num}, {1'b1, 4'd2});
                  check("c6_drawn", drawn, 20'h24800);
                  check("seed6_drawn", drawn6, 20'h28000);
                  check("seed6_hex4", g4, 7'b0100100);
                  check("seed0_drawn", drawn0, 20'h37542);
        goto(9);  check("c9_insert_num", {insert, num}, {1'b1, 4'd4});
        goto(10); draw = 1'b1;
        goto(11); draw = 1'b0;
        goto(12); check("c12_insert_num", {insert, num}, {1'b1, 4'd8});
        goto(18); check("c18_insert_num", {insert, num}, {1'b1, 4'd0});
        goto(21); check("c21_finish", {finish, busy, done}, 3'b110);
        goto(22); check("c22_done", {finish, busy, done}, 3'b001);
                  check("c22_hex", {h4, h3, h2, h1, h0},
                        {7'b0100100, 7'b0011001, 7'b0000000, 7'b1000000, 7'b1000000});
                  check("basic_counts", {n_ins - bi, n_fin - bf}, {32'd5, 32'd1});

        // Reset during transmission, then a fresh draw.
        reset_and_draw(1'b0);
        goto(13); reset = 1'b1; bf = n_fin;
        goto(14); check("midrst_out", {num, insert, finish, busy, done, drawn}, '0);
                  check("midrst_hex", {h4, h3, h2, h1, h0}, {5{7'b1111111}});
        reset = 1'b0; draw = 1'b1; cyc = 0;
        goto(1); draw = 1'b0;
        goto(6);  check("fresh_c6", {insert, num}, {1'b1, 4'd2});
        goto(22); check("fresh_drawn", drawn, 20'h24800);
                  check("fresh_one_finish", n_fin - bf, 1);

        // Back-to-back draws with draw held.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; draw = 1'b1; cyc = 0; bi = n_ins; bf = n_fin;
        goto(22); check("b2b_done1", {busy, done}, 2'b01);
        goto(23); check("b2b_restart", {busy, done}, 2'b10);
        draw = 1'b0;
        goto(44); check("b2b_done2", {busy, done}, 2'b01);
                  check("b2b_counts", {n_ins - bi, n_fin - bf}, {32'd10, 32'd2});
        goto(45); check("b2b_done_holds", done, 1'b1);

        // Zero seed: 100 consecutive draws with draw held.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; draw0 = 1'b1; b0 = d0_cnt;
        for (int i = 0; i < 3000 && d0_cnt - b0 < 100; i++) @(negedge clk);
        check("seed0_100_draws", d0_cnt - b0 >= 100, 1'b1);
        draw0 = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
